// File: rtl/output_action_applier_pkg.sv
// rtl/output_action_applier_pkg.sv - action word field positions and FSM state encoding
package output_action_applier_pkg;

  localparam int ACT_DST_LSB      = 0;
  localparam int ACT_DST_W        = 8;
  localparam int ACT_DROP_BIT     = 8;
  localparam int ACT_SET_DST_BIT  = 9;
  localparam int ACT_SET_DMAC_BIT = 10;
  localparam int ACT_DMAC_LSB     = 16;
  localparam int ACT_DMAC_W       = 48;

  // Destination-port one-hot lives in this byte of the packet tuser
  localparam int TUSER_DST_LSB    = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/output_action_applier_if.sv
// rtl/output_action_applier_if.sv - packet stream and action stream interfaces
interface output_action_applier_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

interface output_action_applier_act_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tuser, tvalid, input tready);
  modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/output_action_applier.sv
// rtl/output_action_applier.sv - applies one per-packet action (drop / rewrite dst port / rewrite dmac)
module output_action_applier
  import output_action_applier_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_ACT_TDATA_WIDTH    = 256,
  parameter int C_ACT_TUSER_WIDTH    = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  output_action_applier_act_if.slave    s_act,
  output_action_applier_if.slave        s_axis,
  output_action_applier_if.master       m_axis,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_fwd_counter,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_drop_counter
);

  state_t state, state_nxt;

  logic out_free;
  logic load;
  logic use_first;
  logic fwd_inc;
  logic drop_inc;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  first_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] first_user;

  // Only the low action fields and none of the action tuser carry meaning
  logic unused_act;
  assign unused_act = ^{s_act.tuser, s_act.tdata};

  assign out_free = ~m_axis.tvalid | m_axis.tready;

  always_comb begin
    first_data = s_axis.tdata;
    first_user = s_axis.tuser;
    if (s_act.tdata[ACT_SET_DMAC_BIT])
      first_data[ACT_DMAC_W-1:0] = s_act.tdata[ACT_DMAC_LSB +: ACT_DMAC_W];
    if (s_act.tdata[ACT_SET_DST_BIT])
      first_user[TUSER_DST_LSB +: ACT_DST_W] = s_act.tdata[ACT_DST_LSB +: ACT_DST_W];
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Packet and action pop together on the first beat, so an action can never
  // be consumed without the packet it belongs to.
  always_comb begin
    state_nxt     = state;
    s_axis.tready = 1'b0;
    s_act.tready  = 1'b0;
    load          = 1'b0;
    use_first     = 1'b0;
    fwd_inc       = 1'b0;
    drop_inc      = 1'b0;
    if (!axi_reset) begin
      case (state)
        ST_IDLE: begin
          if (s_act.tvalid && s_axis.tvalid && out_free) begin
            s_axis.tready = 1'b1;
            s_act.tready  = 1'b1;
            if (s_act.tdata[ACT_DROP_BIT]) begin
              drop_inc  = 1'b1;
              state_nxt = s_axis.tlast ? ST_IDLE : ST_DROP;
            end else begin
              load      = 1'b1;
              use_first = 1'b1;
              fwd_inc   = 1'b1;
              state_nxt = s_axis.tlast ? ST_IDLE : ST_FWD;
            end
          end
        end
        ST_FWD: begin
          s_axis.tready = out_free;
          if (s_axis.tvalid && out_free) begin
            load = 1'b1;
            if (s_axis.tlast)
              state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          s_axis.tready = 1'b1;
          if (s_axis.tvalid && s_axis.tlast)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= use_first ? first_data : s_axis.tdata;
      m_axis.tkeep  <= s_axis.tkeep;
      m_axis.tuser  <= use_first ? first_user : s_axis.tuser;
      m_axis.tlast  <= s_axis.tlast;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pkt_fwd_counter  <= '0;
      pkt_drop_counter <= '0;
    end else begin
      if (fwd_inc)
        pkt_fwd_counter <= pkt_fwd_counter + C_S_AXI_DATA_WIDTH'(1);
      if (drop_inc)
        pkt_drop_counter <= pkt_drop_counter + C_S_AXI_DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_output_action_applier.sv
// tb/tb_output_action_applier.sv - randomized bench for output_action_applier against a packet-level model
module tb_output_action_applier;

  localparam int DW   = 64;
  localparam int UW   = 32;
  localparam int AW   = 64;
  localparam int AUW  = 16;
  localparam int CW   = 4;
  localparam int CMOD = 1 << CW;
  localparam int NMAX = 64;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic [UW-1:0]   user;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_action_applier_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  output_action_applier_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();
  output_action_applier_act_if #(.TDATA_WIDTH(AW), .TUSER_WIDTH(AUW)) a_if ();
  logic [CW-1:0] fwd_cnt, drop_cnt;

  output_action_applier #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_ACT_TDATA_WIDTH   (AW),
    .C_ACT_TUSER_WIDTH   (AUW),
    .C_S_AXI_DATA_WIDTH  (CW)
  ) dut (
    .axi_aclk        (clk),
    .axi_reset       (rst),
    .s_act           (a_if),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .pkt_fwd_counter (fwd_cnt),
    .pkt_drop_counter(drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fwd  = 0;
  int exp_drop = 0;

  int              plen [NMAX];
  logic [DW-1:0]   bd   [NMAX][4];
  logic [DW/8-1:0] bk   [NMAX][4];
  logic [UW-1:0]   bu   [NMAX][4];
  logic [AW-1:0]   ad   [NMAX];
  beat_t           exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic gen_random(input int n, input int max_len, input int drop_pct);
    for (int p = 0; p < n; p++) begin
      plen[p] = $urandom_range(max_len, 1);
      for (int b = 0; b < 4; b++) begin
        bd[p][b] = {$urandom, $urandom};
        bk[p][b] = 8'($urandom);
        bu[p][b] = $urandom;
      end
      ad[p]    = {$urandom, $urandom};
      ad[p][8] = ($urandom_range(99) < drop_pct);
    end
  endtask

  // Packet-level model: a dropped packet emits nothing, a kept one emits all
  // beats with only the first beat rewritten by its own action.
  task automatic build_expected(input int n);
    beat_t e;
    for (int p = 0; p < n; p++) begin
      if (!ad[p][8]) begin
        for (int b = 0; b < plen[p]; b++) begin
          e.data = bd[p][b];
          e.keep = bk[p][b];
          e.user = bu[p][b];
          e.last = (b == plen[p] - 1);
          if (b == 0 && ad[p][10]) e.data[47:0]  = ad[p][63:16];
          if (b == 0 && ad[p][9])  e.user[31:24] = ad[p][7:0];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_traffic(input int n, input int pv, input int av, input int mr, input int act_delay);
    int pi = 0, bi = 0, ai = 0, cyc = 0, wait_c;
    bit p_acc = 0, a_acc = 0, o_acc = 0, hold = 0, lat = 0, cur_drop = 0;
    beat_t held, ob, eb;
    wait_c = act_delay;
    build_expected(n);
    while ((pi < n || exp_q.size() != 0) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (p_acc) s_if.tvalid = 1'b0;
      if (a_acc) a_if.tvalid = 1'b0;
      if (pi < n) begin
        if (!s_if.tvalid) s_if.tvalid = ($urandom_range(99) < pv);
        s_if.tdata = bd[pi][bi];
        s_if.tkeep = bk[pi][bi];
        s_if.tuser = bu[pi][bi];
        s_if.tlast = (bi == plen[pi] - 1);
      end
      if (ai < n && !a_if.tvalid) begin
        if (wait_c > 0) begin
          if (s_if.tvalid) wait_c--;
        end else begin
          a_if.tvalid = ($urandom_range(99) < av);
        end
      end
      if (ai < n) begin
        a_if.tdata = ad[ai];
        a_if.tuser = ad[ai][AUW-1:0] ^ 16'h5a5a;
      end
      m_if.tready = ($urandom_range(99) < mr);

      @(negedge clk);
      ob = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
      check_eq("fwd_counter", fwd_cnt, exp_fwd % CMOD);
      check_eq("drop_counter", drop_cnt, exp_drop % CMOD);
      if (hold) begin
        check_eq("hold_valid", m_if.tvalid, 1'b1);
        check_eq("hold_beat", ob, held);
      end
      if (lat) check_eq("latency_valid", m_if.tvalid, 1'b1);
      p_acc = s_if.tvalid && s_if.tready;
      a_acc = a_if.tvalid && a_if.tready;
      o_acc = m_if.tvalid && m_if.tready;
      if (p_acc || a_acc) check_eq("act_pop_first_beat", a_acc, p_acc && bi == 0);
      if (s_if.tvalid && bi == 0 && !a_if.tvalid) check_eq("stall_no_act", s_if.tready, 1'b0);
      if (s_if.tvalid && bi != 0 && cur_drop) check_eq("drop_ready", s_if.tready, 1'b1);
      if (o_acc) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", o_acc, 1'b0);
        end else begin
          eb = exp_q.pop_front();
          check_eq("out_beat", ob, eb);
        end
      end
      hold = m_if.tvalid && !m_if.tready;
      held = ob;
      lat  = 0;
      if (p_acc) begin
        if (bi == 0) begin
          cur_drop = ad[pi][8];
          if (cur_drop) exp_drop++;
          else exp_fwd++;
        end
        lat = !cur_drop;
        if (bi == plen[pi] - 1) begin
          pi++;
          bi = 0;
        end else begin
          bi++;
        end
      end
      if (a_acc) ai++;
    end
    check_eq("traffic_done", (pi == n && exp_q.size() == 0), 1'b1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    a_if.tvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_if.tdata = '1; s_if.tkeep = '1; s_if.tuser = '1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    a_if.tdata = '0; a_if.tuser = '0; a_if.tvalid = 1'b1;
    m_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_tvalid", m_if.tvalid, 1'b0);
    check_eq("rst_m_beat", {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}, '0);
    check_eq("rst_s_tready", s_if.tready, 1'b0);
    check_eq("rst_act_tready", a_if.tready, 1'b0);
    check_eq("rst_counters", {fwd_cnt, drop_cnt}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    a_if.tvalid = 1'b0;

    // 3-beat packet held waiting for 10 cycles, then set_dst=0x04 action
    gen_random(1, 3, 0);
    plen[0] = 3;
    ad[0]   = 64'h0000_0000_0000_0204;
    run_traffic(1, 100, 100, 100, 10);

    // dropped 4-beat packet, then set_dmac 0A0B0C0D0E0F
    gen_random(2, 2, 0);
    plen[0] = 4;
    ad[0]   = 64'h0000_0000_0000_0100;
    plen[1] = 2;
    ad[1]   = {48'h0A0B_0C0D_0E0F, 16'h0400};
    run_traffic(2, 100, 100, 100, 0);

    // back-to-back single-beat packets with a stalling sink
    gen_random(8, 1, 0);
    run_traffic(8, 100, 100, 50, 0);

    // mixed random traffic; counters wrap through their narrow width
    gen_random(40, 4, 25);
    run_traffic(40, 70, 60, 60, 0);

    // reset in the middle of a 5-beat packet
    gen_random(1, 1, 0);
    plen[0]  = 5;
    ad[0][8] = 1'b0;
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    a_if.tvalid = 1'b1; a_if.tdata = ad[0];
    s_if.tvalid = 1'b1; s_if.tdata = bd[0][0]; s_if.tkeep = bk[0][0]; s_if.tuser = bu[0][0]; s_if.tlast = 1'b0;
    @(posedge clk); #1;
    a_if.tvalid = 1'b0;
    s_if.tdata = bd[0][1];
    @(posedge clk); #1;
    s_if.tdata = bd[0][2];
    a_if.tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_s_tready", s_if.tready, 1'b0);
    check_eq("midrst_act_tready", a_if.tready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    a_if.tvalid = 1'b0;
    @(negedge clk);
    check_eq("midrst_m_tvalid", m_if.tvalid, 1'b0);
    check_eq("midrst_fwd_counter", fwd_cnt, '0);
    check_eq("midrst_drop_counter", drop_cnt, '0);
    exp_fwd  = 0;
    exp_drop = 0;
    exp_q.delete();

    gen_random(6, 4, 25);
    run_traffic(6, 80, 80, 80, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
